// File: rtl/mem_responder.sv
// Memory/I-O responder for the CPU MAR/MDR interface: programmable wait states,
// one-cycle ready strobe, word-addressed RAM and a memory-mapped I/O word at 0xFFFF.
module mem_responder #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MEM_EN,
  input  logic        WE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  output logic        R,
  output logic [15:0] Data_to_CPU,
  input  logic [15:0] Switches,
  output logic [15:0] HEX_OUT
);

  localparam int          DEPTH     = 2 ** ADDR_W;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT);
  localparam logic [15:0] IO_ADDR   = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, BUSY, ACK, HOLD} state_t;

  state_t      state;
  logic [3:0]  count;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        wr;

  logic [15:0] ram [DEPTH];

  logic              access;
  logic              is_io;
  logic              in_ram;
  logic [ADDR_W-1:0] ram_idx;

  assign access  = (state == BUSY) && (count == 4'd0);
  assign is_io   = (addr == IO_ADDR);
  assign in_ram  = ({1'b0, addr} < 17'(DEPTH));
  assign ram_idx = addr[ADDR_W-1:0];

  // RAM has no reset; a reset on the access edge suppresses the write
  always_ff @(posedge Clk) begin
    if (!Reset && access && wr && in_ram && !is_io) begin
      ram[ram_idx] <= wdata;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      count       <= 4'd0;
      R           <= 1'b0;
      Data_to_CPU <= 16'h0000;
      HEX_OUT     <= 16'h0000;
      addr        <= 16'h0000;
      wdata       <= 16'h0000;
      wr          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (MEM_EN) begin
            addr  <= MAR;
            wdata <= MDR;
            wr    <= WE;
            count <= WAIT_INIT;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            state <= ACK;
            R     <= 1'b1;
            // I/O decode wins over RAM so 0xFFFF is never a RAM word
            if (!wr) begin
              if (is_io)       Data_to_CPU <= Switches;
              else if (in_ram) Data_to_CPU <= ram[ram_idx];
              else             Data_to_CPU <= 16'h0000;
            end else if (is_io) begin
              HEX_OUT <= wdata;
            end
          end
        end
        ACK: begin
          R     <= 1'b0;
          state <= MEM_EN ? HOLD : IDLE;
        end
        HOLD: begin
          if (!MEM_EN) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
